// File: rtl/hvsync_decoder_pkg.sv
// rtl/hvsync_decoder_pkg.sv - widths, lock FSM states and counter helper for the sync decoder
package hvsync_decoder_pkg;

   localparam int POS_W = 9;
   localparam int WD_W  = 10;
   localparam int CNT_W = 3;

   typedef logic [1:0] lock_state_t;

   localparam lock_state_t ST_SEARCH = 2'd0;
   localparam lock_state_t ST_VERIFY = 2'd1;
   localparam lock_state_t ST_LOCKED = 2'd2;

   function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] v, input int last);
      logic [31:0] last_v;
      last_v = last;
      return (v == last_v[POS_W-1:0]) ? '0 : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_lock_tracker.sv
// rtl/sync_lock_tracker.sv - one-axis lock FSM with consecutive-good counter and saturating watchdog
module sync_lock_tracker
   import hvsync_decoder_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LIMIT      = 618
)(
   input  logic clk,
   input  logic reset,
   input  logic sync_edge,
   input  logic good,
   input  logic tick,
   output logic locked,
   output logic err
);
   localparam logic [WD_W-1:0]  WD_LIM    = WD_W'(LIMIT);
   localparam logic [WD_W-1:0]  WD_LIM_M1 = WD_W'(LIMIT - 1);
   // cnt counts good periods after the first edge; lock once cnt+1 reaches LOCK_COUNT-1
   localparam logic [CNT_W-1:0] CNT_DONE  = (LOCK_COUNT >= 2) ? CNT_W'(LOCK_COUNT - 2) : '0;

   lock_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [WD_W-1:0]  wd;
   logic             timeout;

   assign timeout = (wd == WD_LIM) | (tick & (wd == WD_LIM_M1));
   assign locked  = (state == ST_LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_SEARCH;
         cnt   <= '0;
         wd    <= '0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         if (sync_edge)
            wd <= '0;
         else if (tick && wd != WD_LIM)
            wd <= wd + 1'b1;

         if (sync_edge) begin
            case (state)
               ST_SEARCH: begin
                  state <= ST_VERIFY;
                  cnt   <= '0;
               end
               ST_VERIFY: begin
                  if (good) begin
                     cnt <= cnt + 1'b1;
                     if (cnt >= CNT_DONE)
                        state <= ST_LOCKED;
                  end else begin
                     cnt <= '0;
                  end
               end
               default: begin
                  if (!good) begin
                     state <= ST_VERIFY;
                     cnt   <= '0;
                     err   <= 1'b1;
                  end
               end
            endcase
         end else if (timeout) begin
            state <= ST_SEARCH;
            cnt   <= '0;
            err   <= (state == ST_LOCKED);
         end
      end
   end
endmodule

// File: rtl/video_timing.vh
// rtl/video_timing.vh - default video geometry shared by the sync generator and decoder
`ifndef VIDEO_TIMING_VH
`define VIDEO_TIMING_VH

`define VT_H_DISPLAY    256
`define VT_H_BACK       23
`define VT_H_FRONT      7
`define VT_H_SYNC       23
`define VT_V_DISPLAY    240
`define VT_V_TOP        4
`define VT_V_BOTTOM     14
`define VT_V_SYNC       4

`define VT_H_TOTAL      (`VT_H_DISPLAY + `VT_H_BACK + `VT_H_FRONT + `VT_H_SYNC)
`define VT_H_SYNC_START (`VT_H_DISPLAY + `VT_H_FRONT)
`define VT_V_TOTAL      (`VT_V_DISPLAY + `VT_V_TOP + `VT_V_BOTTOM + `VT_V_SYNC)
`define VT_V_SYNC_START (`VT_V_DISPLAY + `VT_V_BOTTOM)

`endif

// File: rtl/hvsync_decoder.sv
// rtl/hvsync_decoder.sv - recovers hpos/vpos from external hsync/vsync and reports per-axis lock
`include "video_timing.vh"
module hvsync_decoder
   import hvsync_decoder_pkg::*;
#(
   parameter int H_DISPLAY  = `VT_H_DISPLAY,
   parameter int H_BACK     = `VT_H_BACK,
   parameter int H_FRONT    = `VT_H_FRONT,
   parameter int H_SYNC     = `VT_H_SYNC,
   parameter int V_DISPLAY  = `VT_V_DISPLAY,
   parameter int V_TOP      = `VT_V_TOP,
   parameter int V_BOTTOM   = `VT_V_BOTTOM,
   parameter int V_SYNC     = `VT_V_SYNC,
   parameter int LOCK_COUNT = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             hsync,
   input  logic             vsync,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             display_on,
   output logic             h_locked,
   output logic             v_locked,
   output logic             frame_start,
   output logic             sync_err
);
   localparam int H_TOTAL      = H_DISPLAY + H_BACK + H_FRONT + H_SYNC;
   localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam int V_TOTAL      = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC;
   localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;

   logic hsync_q, vsync_q;
   logic hrise, vrise, hwrap;
   logic h_good, v_good, h_err, v_err;

   assign hrise  = hsync & ~hsync_q;
   assign vrise  = vsync & ~vsync_q;
   assign hwrap  = (hpos == POS_W'(H_TOTAL - 1)) & ~hrise;
   assign h_good = hrise & (hpos == POS_W'(H_SYNC_START));
   assign v_good = vrise & (vpos == POS_W'(V_SYNC_START));

   // sync history resets high so a sync already asserted at release is not an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         hpos    <= '0;
         vpos    <= '0;
      end else begin
         hsync_q <= hsync;
         vsync_q <= vsync;
         hpos    <= hrise ? POS_W'(H_SYNC_START + 1) : wrap_inc(hpos, H_TOTAL - 1);
         if (vrise)
            vpos <= POS_W'(V_SYNC_START);
         else if (hwrap)
            vpos <= wrap_inc(vpos, V_TOTAL - 1);
      end
   end

   sync_lock_tracker #(.LOCK_COUNT(LOCK_COUNT), .LIMIT(2 * H_TOTAL)) u_h_lock (
      .clk       (clk),
      .reset     (reset),
      .sync_edge (hrise),
      .good      (h_good),
      .tick      (1'b1),
      .locked    (h_locked),
      .err       (h_err)
   );

   sync_lock_tracker #(.LOCK_COUNT(LOCK_COUNT), .LIMIT(2 * V_TOTAL)) u_v_lock (
      .clk       (clk),
      .reset     (reset),
      .sync_edge (vrise),
      .good      (v_good),
      .tick      (hwrap),
      .locked    (v_locked),
      .err       (v_err)
   );

   assign sync_err    = h_err | v_err;
   assign display_on  = h_locked & v_locked & (hpos < POS_W'(H_DISPLAY)) & (vpos < POS_W'(V_DISPLAY));
   assign frame_start = h_locked & v_locked & (hpos == '0) & (vpos == '0);
endmodule

// File: tb/tb_hvsync_decoder.sv
// tb/tb_hvsync_decoder.sv - directed bench: default-geometry horizontal cases and a small full-frame instance
module tb_hvsync_decoder;
   localparam int BH_D = 16, BH_B = 3, BH_F = 2, BH_S = 4;
   localparam int BV_D = 10, BV_T = 2, BV_B = 3, BV_S = 2;
   localparam int BH_TOT = 25, BH_SS = 18, BV_TOT = 17, BV_SS = 13;
   localparam int B_FRAME = BH_TOT * BV_TOT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, hsync_a, vsync_a;
   logic [8:0] hpos_a, vpos_a;
   logic       display_on_a, h_locked_a, v_locked_a, frame_start_a, sync_err_a;

   logic       reset_b, hsync_b, vsync_b;
   logic [8:0] hpos_b, vpos_b;
   logic       display_on_b, h_locked_b, v_locked_b, frame_start_b, sync_err_b;

   hvsync_decoder dut_a (
      .clk(clk), .reset(reset_a), .hsync(hsync_a), .vsync(vsync_a),
      .hpos(hpos_a), .vpos(vpos_a), .display_on(display_on_a), .h_locked(h_locked_a),
      .v_locked(v_locked_a), .frame_start(frame_start_a), .sync_err(sync_err_a)
   );

   hvsync_decoder #(
      .H_DISPLAY(BH_D), .H_BACK(BH_B), .H_FRONT(BH_F), .H_SYNC(BH_S),
      .V_DISPLAY(BV_D), .V_TOP(BV_T), .V_BOTTOM(BV_B), .V_SYNC(BV_S), .LOCK_COUNT(4)
   ) dut_b (
      .clk(clk), .reset(reset_b), .hsync(hsync_b), .vsync(vsync_b),
      .hpos(hpos_b), .vpos(vpos_b), .display_on(display_on_b), .h_locked(h_locked_b),
      .v_locked(v_locked_b), .frame_start(frame_start_b), .sync_err(sync_err_b)
   );

   int checks = 0;
   int errors = 0;
   int err_a_cnt = 0;
   int gh = 0;
   int gv = 0;

   always @(negedge clk) if (sync_err_a === 1'b1) err_a_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_rise();
      hsync_a = 1'b1;
      tick();
   endtask

   task automatic a_rest(input int len);
      for (int i = 1; i < len; i++) begin
         hsync_a = (i < 23);
         tick();
      end
   endtask

   task automatic b_step();
      hsync_b = (gh >= BH_SS) && (gh < BH_SS + BH_S);
      vsync_b = (gv >= BV_SS) && (gv < BV_SS + BV_S);
      tick();
      gh++;
      if (gh == BH_TOT) begin
         gh = 0;
         gv = (gv + 1) % BV_TOT;
      end
   endtask

   task automatic b_acquire(output int nh, output int nv, output int nerr);
      reset_b = 1'b0;
      gh = 0;
      gv = 0;
      nh = 0;
      nv = 0;
      nerr = 0;
      for (int n = 1; n <= 5 * B_FRAME; n++) begin
         b_step();
         if (h_locked_b && nh == 0) nh = n;
         if (v_locked_b && nv == 0) nv = n;
         if (sync_err_b) nerr++;
      end
   endtask

   task automatic b_frame_check(input string tag);
      int disp, fs, bad;
      disp = 0;
      fs = 0;
      bad = 0;
      for (int n = 0; n < B_FRAME; n++) begin
         b_step();
         if (display_on_b) disp++;
         if (frame_start_b) fs++;
         if (hpos_b != 9'(gh) || vpos_b != 9'(gv)) bad++;
      end
      check({tag, "_display_cnt"}, 32'(disp), 32'(BH_D * BV_D));
      check({tag, "_frame_start_cnt"}, 32'(fs), 32'd1);
      check({tag, "_pos_track_bad"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int nh, nv, nerr, first;
      reset_a = 1'b1; hsync_a = 1'b1; vsync_a = 1'b0;
      reset_b = 1'b1; hsync_b = 1'b0; vsync_b = 1'b0;
      repeat (2) tick();
      check("a_reset_pos", {hpos_a, vpos_a}, 32'd0);
      check("a_reset_flags", {display_on_a, frame_start_a, sync_err_a, h_locked_a, v_locked_a}, 32'd0);

      // hsync already high at release must not count as an edge
      reset_a = 1'b0;
      repeat (5) tick();
      check("a_no_edge_at_release", 32'(hpos_a), 32'd5);
      hsync_a = 1'b0;
      repeat (2) tick();
      a_rise();
      check("a_first_rise_hpos", 32'(hpos_a), 32'd264);
      check("a_first_rise_unlocked", 32'(h_locked_a), 32'd0);

      for (int k = 1; k <= 3; k++) begin
         a_rest(309);
         a_rise();
         check($sformatf("a_hlock_line%0d", k), 32'(h_locked_a), 32'(k == 3));
         check($sformatf("a_vpos_line%0d", k), 32'(vpos_a), 32'(k));
      end
      check("a_locked_hpos", 32'(hpos_a), 32'd264);
      check("a_locked_no_err", 32'(err_a_cnt), 32'd0);
      check("a_display_off_v_unlocked", 32'(display_on_a), 32'd0);

      // one short line: single error pulse, relock after three good lines
      a_rest(300);
      a_rise();
      check("a_short_err", 32'(sync_err_a), 32'd1);
      check("a_short_unlocked", 32'(h_locked_a), 32'd0);
      check("a_short_resync_hpos", 32'(hpos_a), 32'd264);
      check("a_short_vpos", 32'(vpos_a), 32'd4);
      for (int k = 1; k <= 3; k++) begin
         a_rest(309);
         a_rise();
         check($sformatf("a_relock_line%0d", k), 32'(h_locked_a), 32'(k == 3));
         check($sformatf("a_relock_vpos%0d", k), 32'(vpos_a), 32'(4 + k));
      end
      check("a_short_err_pulses", 32'(err_a_cnt), 32'd1);

      // hsync stops toggling: watchdog fires 618 clocks after the last rise
      first = 0;
      for (int i = 1; i <= 700; i++) begin
         hsync_a = (i < 23);
         tick();
         if (sync_err_a && first == 0) first = i;
      end
      check("a_timeout_clock", 32'(first), 32'd618);
      check("a_timeout_unlocked", 32'(h_locked_a), 32'd0);
      check("a_timeout_display", 32'(display_on_a), 32'd0);
      check("a_timeout_err_pulses", 32'(err_a_cnt), 32'd2);

      // vrise landing on the hwrap cycle
      reset_a = 1'b1; hsync_a = 1'b0; vsync_a = 1'b0;
      tick();
      reset_a = 1'b0;
      repeat (308) tick();
      check("a_pre_wrap_hpos", 32'(hpos_a), 32'd308);
      vsync_a = 1'b1;
      tick();
      check("a_vrise_on_wrap_vpos", 32'(vpos_a), 32'd254);
      check("a_vrise_on_wrap_hpos", 32'(hpos_a), 32'd0);

      // small-geometry instance: full lock, frame content, mid-frame reset and relock
      tick();
      check("b_reset_state", {hpos_b, vpos_b, display_on_b, frame_start_b, sync_err_b, h_locked_b, v_locked_b}, 32'd0);
      b_acquire(nh, nv, nerr);
      check("b_hlock_step", 32'(nh), 32'd94);
      check("b_vlock_step", 32'(nv), 32'd1601);
      check("b_acquire_errs", 32'(nerr), 32'd0);
      b_frame_check("b_frame1");

      repeat (200) b_step();
      reset_b = 1'b1;
      tick();
      check("b_midreset_pos", {hpos_b, vpos_b}, 32'd0);
      check("b_midreset_flags", {display_on_b, frame_start_b, sync_err_b, h_locked_b, v_locked_b}, 32'd0);
      b_acquire(nh, nv, nerr);
      check("b_relock_hstep", 32'(nh), 32'd94);
      check("b_relock_vstep", 32'(nv), 32'd1601);
      check("b_relock_errs", 32'(nerr), 32'd0);
      b_frame_check("b_frame2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hvsync_decoder.md
Name: hvsync_decoder

Overview:
- Receive-side counterpart of the sync generator. Takes active-high hsync/vsync at one sample per pixel clock.
- Recovers the horizontal and vertical position counters, verifies line and frame periods, and reports lock.
- Sits in front of pixel-capture and overlay logic that must align to an external timing source.
- Default geometry: 256x240 visible, 309 clocks/line, 262 lines/frame.

Parameters:
H_DISPLAY, 256, visible pixels per line
H_BACK, 23, left border clocks
H_FRONT, 7, right border clocks
H_SYNC, 23, hsync width in clocks
V_DISPLAY, 240, visible lines
V_TOP, 4, top border lines
V_BOTTOM, 14, bottom border lines
V_SYNC, 4, vsync width in lines
LOCK_COUNT, 4, consecutive good periods required to declare lock (1..7)

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
hsync  input  1  active-high horizontal sync
vsync  input  1  active-high vertical sync
hpos  output  9  recovered horizontal position
vpos  output  9  recovered vertical position
display_on  output  1  locked and inside the visible area
h_locked  output  1  horizontal lock
v_locked  output  1  vertical lock
frame_start  output  1  one-cycle pulse at hpos=0, vpos=0 while locked
sync_err  output  1  one-cycle pulse on period mismatch or timeout, either axis

Behaviour:
- Constants: H_TOTAL = H_DISPLAY+H_BACK+H_FRONT+H_SYNC (309); H_SYNC_START = H_DISPLAY+H_FRONT (263); V_TOTAL = V_DISPLAY+V_TOP+V_BOTTOM+V_SYNC (262); V_SYNC_START = V_DISPLAY+V_BOTTOM (254).
- Edge detect:
  - hsync_q and vsync_q register the inputs.
  - hrise = hsync & ~hsync_q; vrise = vsync & ~vsync_q.
  - Reset sets hsync_q = vsync_q = 1, so a sync already high when reset releases is not counted as an edge.
- hpos:
  - On hrise, next hpos = H_SYNC_START+1.
  - Otherwise hpos increments, wrapping H_TOTAL-1 -> 0.
  - hwrap = (hpos == H_TOTAL-1) & ~hrise.
- vpos:
  - On vrise, next vpos = V_SYNC_START; vrise takes priority over hwrap in the same cycle.
  - Otherwise vpos increments on hwrap, wrapping V_TOTAL-1 -> 0.
- Period check:
  - H good edge: hrise and hpos == H_SYNC_START in that cycle. An hrise with any other hpos is bad.
  - V good edge: vrise and vpos == V_SYNC_START. A vrise with any other vpos is bad.
- Per-axis lock FSM (SEARCH, VERIFY, LOCKED):
  - SEARCH: first edge -> VERIFY with cnt=0.
  - VERIFY: good edge increments cnt; when cnt reaches LOCK_COUNT-1, move to LOCKED. Bad edge sets cnt=0 and stays in VERIFY.
  - LOCKED: bad edge -> VERIFY with cnt=0 and pulses sync_err.
  - Timeout from any state -> SEARCH; pulses sync_err only if the axis was LOCKED.
- Watchdogs:
  - H: 10-bit count of clocks since the last hrise; timeout when it reaches 2*H_TOTAL (618).
  - V: 10-bit count of hwraps since the last vrise; timeout at 2*V_TOTAL (524).
  - Each watchdog clears on its own edge and saturates (no wrap).
- Lock outputs: h_locked = (H FSM == LOCKED); v_locked = (V FSM == LOCKED). Both are registered, no extra latency.
- display_on = h_locked & v_locked & (hpos < H_DISPLAY) & (vpos < V_DISPLAY). Combinational from registers.
- frame_start = h_locked & v_locked & hpos==0 & vpos==0.
- sync_err: if both axes error in the same cycle, it is a single pulse.
- Reset values: hpos=0, vpos=0, both FSMs SEARCH, cnt=0, watchdogs=0, all 1-bit outputs 0.
  - Reset asserted mid-frame returns everything to these values on the next edge.
- Edge cases:
  - Hsync stuck high: no hrise, so the H watchdog times out.
  - Spurious extra hrise mid-line: bad edge, H drops to VERIFY, hpos resyncs immediately.

Decomposition:
- Shared include video_timing.vh (include-guarded) holds the H_/V_ defaults and the derived TOTAL and SYNC_START constants. The same include is used by the sync generator.
- One sub-module, sync_lock_tracker. It holds one FSM, cnt and watchdog, with inputs edge, good, tick and timeout limit, and outputs locked and err.
- Instantiated twice: horizontal with tick = clk, vertical with tick = hwrap.

Test Plan:
- Drive from the sync generator after reset: h_locked rises within 4 lines + 1 clock; v_locked rises after 4 frames; then hpos/vpos match the generator with fixed 1-clock offset; display_on high for exactly 256x240 clocks per frame.
- Locked, then one line shortened to 300 clocks: one sync_err pulse; h_locked low for 3 following lines, then high again; vpos unaffected.
- Locked, then hsync held low 700 clocks: sync_err at clock 618 after the last hrise; H FSM in SEARCH; display_on=0.
- Reset released with hsync=1: no edge counted; first hrise occurs only after hsync drops and rises again.
- vrise coinciding with hwrap at hpos=308: vpos = 254, not 0 or 255.
- Locked, then reset for 1 cycle mid-frame: all outputs 0 next cycle; relock sequence identical to the first scenario.
